host_stream_tx: RTL and testbench

//  Host-side transmitter for the 32-bit command stream consumed by the accelerator input interface.

---
 rtl/host_stream_tx.sv | 208 ++++++++++++++++++++
 tb/tb_host_stream_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_stream_tx.sv
// rtl/host_stream_tx.sv - host-side command stream transmitter with result capture (optional SIZE_HDR_EN size header)
module host_stream_tx #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic [31:0]       cmd_op,
    input  logic [31:0]       cmd_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              send,
    input  logic [15:0]       exp_out,
`ifdef SIZE_HDR_EN
    input  logic [8:0]        cfg_size,
`endif
    output logic [31:0]       link_data,
    output logic              link_enable,
    input  logic [31:0]       link_y,
    input  logic              link_y_valid,
    output logic [31:0]       res_data,
    output logic              res_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   pending
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR_SIZE = 3'd1,
        ST_HDR_OUT  = 3'd2,
        ST_HDR_CNT  = 3'd3,
        ST_OP       = 3'd4,
        ST_DAT      = 3'd5,
        ST_DRAIN    = 3'd6
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);

    state_t              r_state;
    state_t              w_next_state;
    logic [63:0]         r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     r_n;
    logic [15:0]         r_e;
    logic [15:0]         r_rx_cnt;
    logic                r_link_enable;
    logic [31:0]         r_res_data;
    logic                r_res_valid;

    logic                w_cmd_ready;
    logic                w_push;
    logic                w_pop;
    logic                w_accept;
    logic                w_counting;
    logic [63:0]         w_head;
    logic [31:0]         w_link_data;
    logic                w_done;

    // Header word: marker byte 0x64 distinguishes headers from the all-zero idle word.
    function automatic logic [31:0] hdr_word(input logic [3:0] t, input logic [15:0] v);
        return {4'h0, 8'h64, t, v};
    endfunction

    // cmd_ready is held low during reset and until link_enable rises, so every output is 0 in reset.
    assign w_cmd_ready = r_link_enable && (r_count != FULL_CNT) && (r_state == ST_IDLE);
    assign w_push      = cmd_valid && w_cmd_ready;
    assign w_pop       = (r_state == ST_DAT);
    assign w_accept    = (r_state == ST_IDLE) && send && (r_count != '0);
    assign w_counting  = (r_state == ST_OP) || (r_state == ST_DAT) || (r_state == ST_DRAIN);
    assign w_head      = r_mem[r_rd_ptr];

    // Pair storage; no reset needed because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_op, cmd_data};
        end
    end

    // FIFO pointers and occupancy; push only happens in IDLE and pop only in DAT.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Burst bookkeeping: N and E latched on an accepted send, N counts down per popped pair.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_n <= '0;
            r_e <= '0;
        end else if (w_accept) begin
            r_n <= r_count;
            r_e <= exp_out;
        end else if (w_pop) begin
            r_n <= r_n - ONE_CNT;
        end
    end

    // Result counter: cleared per burst, counts only while the payload or drain is in flight.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_rx_cnt <= '0;
        end else if (w_accept) begin
            r_rx_cnt <= '0;
        end else if (link_y_valid && w_counting && (r_rx_cnt != 16'hFFFF)) begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
        end
    end

    // Link enable rises on the first clock after reset; results are registered every cycle.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_link_enable <= 1'b0;
            r_res_data    <= '0;
            r_res_valid   <= 1'b0;
        end else begin
            r_link_enable <= 1'b1;
            r_res_data    <= link_y;
            r_res_valid   <= link_y_valid;
        end
    end

    // Next-state and stream word selection.
    always_comb begin
        w_next_state = r_state;
        w_link_data  = '0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
`ifdef SIZE_HDR_EN
                    w_next_state = ST_HDR_SIZE;
`else
                    w_next_state = ST_HDR_OUT;
`endif
                end
            end
            ST_HDR_SIZE: begin
`ifdef SIZE_HDR_EN
                w_link_data = hdr_word(4'd2, {7'h0, cfg_size});
`endif
                w_next_state = ST_HDR_OUT;
            end
            ST_HDR_OUT: begin
                w_link_data  = hdr_word(4'd1, r_e);
                w_next_state = ST_HDR_CNT;
            end
            ST_HDR_CNT: begin
                w_link_data  = hdr_word(4'd0, 16'(r_n));
                w_next_state = ST_OP;
            end
            ST_OP: begin
                w_link_data  = w_head[63:32];
                w_next_state = ST_DAT;
            end
            ST_DAT: begin
                w_link_data  = w_head[31:0];
                w_next_state = (r_n > ONE_CNT) ? ST_OP : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_rx_cnt == r_e) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready   = w_cmd_ready;
    assign link_data   = w_link_data;
    assign link_enable = r_link_enable;
    assign res_data    = r_res_data;
    assign res_valid   = r_res_valid;
    assign busy        = (r_state != ST_IDLE);
    assign done        = w_done;
    assign pending     = r_count;

endmodule

// File: tb/tb_host_stream_tx.sv
// tb/tb_host_stream_tx.sv - self-checking bench for host_stream_tx
module tb_host_stream_tx;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
`ifdef SIZE_HDR_EN
    localparam int H = 3;
`else
    localparam int H = 2;
`endif

    logic              clk = 1'b0;
    logic              clear_n;
    logic [31:0]       cmd_op;
    logic [31:0]       cmd_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              send;
    logic [15:0]       exp_out;
    logic [8:0]        cfg_size;
    logic [31:0]       link_data;
    logic              link_enable;
    logic [31:0]       link_y;
    logic              link_y_valid;
    logic [31:0]       res_data;
    logic              res_valid;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   pending;

    host_stream_tx #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .clear_n      (clear_n),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .send         (send),
        .exp_out      (exp_out),
`ifdef SIZE_HDR_EN
        .cfg_size     (cfg_size),
`endif
        .link_data    (link_data),
        .link_enable  (link_enable),
        .link_y       (link_y),
        .link_y_valid (link_y_valid),
        .res_data     (res_data),
        .res_valid    (res_valid),
        .busy         (busy),
        .done         (done),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [15:0] e;
        int          nres;
        int          dly;
        logic [31:0] op0;
        logic [31:0] hdr_e;
        logic [31:0] hdr_n;
    } vec_t;

    vec_t vecs [5];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic enqueue(input int n, input logic [31:0] op0, input int pend0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1;
            cmd_op    = op0 + 32'(i);
            cmd_data  = (op0 + 32'(i)) ^ 32'hA6;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("enq_pending", 32'(pending), 32'(pend0 + n));
        chk("enq_ready", 32'(cmd_ready), ((pend0 + n) < DEPTH) ? 32'd1 : 32'd0);
        if (pend0 + n == DEPTH) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1;
            cmd_op    = 32'hDEAD_BEEF;
            cmd_data  = 32'hDEAD_BEEF;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            @(negedge clk);
            chk("full_no_push", 32'(pending), 32'(DEPTH));
        end
    endtask

    task automatic send_pulse(input logic [15:0] e);
        @(posedge clk); #1;
        exp_out = e;
        send    = 1'b1;
        @(posedge clk); #1;
        send    = 1'b0;
    endtask

    // Called right after the send edge: checks every stream word, result forwarding and done timing.
    task automatic stream_check(input int n, input int nres, input int dly, input logic [31:0] op0,
                                input logic [31:0] hdr_e, input logic [31:0] hdr_n,
                                input int pend_end, input string name);
        logic [31:0] w;
        logic        pv;
        logic [31:0] pd;
        int          sent;
        int          got;
        int          p;
        pv   = 1'b0;
        pd   = '0;
        sent = 0;
        got  = -1;
        for (int k = 0; k < H + 2 * n; k++) begin
            @(negedge clk);
            if (k < H - 2) begin
                w = 32'h0642_004F;
            end else if (k == H - 2) begin
                w = hdr_e;
            end else if (k == H - 1) begin
                w = hdr_n;
            end else begin
                p = k - H;
                w = ((p % 2) == 0) ? (op0 + 32'(p / 2)) : ((op0 + 32'(p / 2)) ^ 32'hA6);
            end
            chk($sformatf("%s_word%0d", name, k), link_data, w);
            chk($sformatf("%s_nodone%0d", name, k), 32'(done), 32'd0);
            if (k == 0) begin
                chk($sformatf("%s_busy", name), 32'(busy), 32'd1);
                chk($sformatf("%s_ready_busy", name), 32'(cmd_ready), 32'd0);
            end
            chk($sformatf("%s_resv%0d", name, k), 32'(res_valid), 32'(pv));
            if (pv) begin
                chk($sformatf("%s_resd%0d", name, k), res_data, pd);
            end
            if (k >= H && sent < nres) begin
                link_y_valid = 1'b1;
                link_y       = 32'hC000_0000 + 32'(sent);
                sent++;
            end else begin
                link_y_valid = 1'b0;
            end
            pv = link_y_valid;
            pd = link_y;
        end
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = j;
                break;
            end
            if (sent < nres) begin
                link_y_valid = 1'b1;
                link_y       = 32'hC000_0000 + 32'(sent);
                sent++;
            end else begin
                link_y_valid = 1'b0;
            end
        end
        link_y_valid = 1'b0;
        chk($sformatf("%s_done_delay", name), 32'(got), 32'(dly));
        @(negedge clk);
        chk($sformatf("%s_done_pulse", name), 32'(done), 32'd0);
        chk($sformatf("%s_idle_busy", name), 32'(busy), 32'd0);
        chk($sformatf("%s_idle_word", name), link_data, 32'd0);
        chk($sformatf("%s_pend_end", name), 32'(pending), 32'(pend_end));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{n: 1,  e: 16'd1, nres: 1, dly: 0, op0: 32'h0000_0003, hdr_e: 32'h0641_0001, hdr_n: 32'h0640_0001};
        vecs[1] = '{n: 16, e: 16'd3, nres: 3, dly: 0, op0: 32'h0000_0100, hdr_e: 32'h0641_0003, hdr_n: 32'h0640_0010};
        vecs[2] = '{n: 2,  e: 16'd0, nres: 0, dly: 0, op0: 32'h0000_0200, hdr_e: 32'h0641_0000, hdr_n: 32'h0640_0002};
        vecs[3] = '{n: 1,  e: 16'd3, nres: 3, dly: 1, op0: 32'h0000_0280, hdr_e: 32'h0641_0003, hdr_n: 32'h0640_0001};
        vecs[4] = '{n: 3,  e: 16'd2, nres: 2, dly: 0, op0: 32'h0000_02C0, hdr_e: 32'h0641_0002, hdr_n: 32'h0640_0003};

        clear_n      = 1'b0;
        cmd_op       = '0;
        cmd_data     = '0;
        cmd_valid    = 1'b0;
        send         = 1'b0;
        exp_out      = '0;
        cfg_size     = 9'h04F;
        link_y       = '0;
        link_y_valid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_link_data", link_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_link_enable", 32'(link_enable), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        clear_n = 1'b1;
        @(negedge clk);
        chk("rel_link_enable_low", 32'(link_enable), 32'd0);
        @(negedge clk);
        chk("rel_link_enable_high", 32'(link_enable), 32'd1);

        for (int i = 0; i < 5; i++) begin
            enqueue(vecs[i].n, vecs[i].op0, 0);
            send_pulse(vecs[i].e);
            stream_check(vecs[i].n, vecs[i].nres, vecs[i].dly, vecs[i].op0,
                         vecs[i].hdr_e, vecs[i].hdr_n, 0, $sformatf("vec%0d", i));
        end

        // Send with an empty FIFO must be ignored.
        send_pulse(16'd5);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("empty_send_busy%0d", k), 32'(busy), 32'd0);
            chk($sformatf("empty_send_word%0d", k), link_data, 32'd0);
            chk($sformatf("empty_send_done%0d", k), 32'(done), 32'd0);
        end

        // Results arriving in IDLE are still forwarded.
        @(posedge clk); #1;
        link_y_valid = 1'b1;
        link_y       = 32'h1234_5678;
        @(posedge clk); #1;
        link_y_valid = 1'b0;
        @(negedge clk);
        chk("idle_res_valid", 32'(res_valid), 32'd1);
        chk("idle_res_data", res_data, 32'h1234_5678);
        @(negedge clk);
        chk("idle_res_valid_drop", 32'(res_valid), 32'd0);

        // Simultaneous enqueue and send: the new pair waits for the next burst.
        enqueue(1, 32'h0000_0300, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = 32'h0000_0301;
        cmd_data  = 32'h0000_0301 ^ 32'hA6;
        exp_out   = 16'd0;
        send      = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        send      = 1'b0;
        stream_check(1, 0, 0, 32'h0000_0300, 32'h0641_0000, 32'h0640_0001, 1, "simul");
        send_pulse(16'd0);
        stream_check(1, 0, 0, 32'h0000_0301, 32'h0641_0000, 32'h0640_0001, 0, "next");

        // Reset in the middle of a burst aborts it.
        enqueue(4, 32'h0000_0400, 0);
        send_pulse(16'd1);
        repeat (3) @(posedge clk);
        #1;
        clear_n = 1'b0;
        #1;
        chk("mid_rst_link_data", link_data, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_link_enable", 32'(link_enable), 32'd0);
        @(posedge clk); #1;
        clear_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_done%0d", k), 32'(done), 32'd0);
            chk($sformatf("post_rst_busy%0d", k), 32'(busy), 32'd0);
        end
        chk("post_rst_link_enable", 32'(link_enable), 32'd1);
        chk("post_rst_pending", 32'(pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
